// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arb_pkg                                                     |
// | Purpose  : Shared types and defaults for the two-requester Pmem arbiter.   |
// |            Provides the arbiter state encoding, the requester index type   |
// |            and the default bus widths.                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

   localparam int c_addr_w_def  = 32;
   localparam int c_data_w_def  = 64;
   localparam int c_timeout_def = 255;

   // One bit selects between the two requesters.
   typedef logic rq_idx_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_BUSY = 2'd1,
      WR_BUSY = 2'd2
   } arb_state_t;

   // One-hot requester vector for a requester index.
   function automatic logic [1:0] idx_onehot(input rq_idx_t idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_pick                                                         |
// | Purpose  : Combinational 2-way round-robin picker.                         |
// | Ports    : req[1:0]  - request per requester                            |
// |            last      - index of the last-served requester               |
// |            gnt_idx   - winning requester index                          |
// |            gnt_any   - at least one request present                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  rq_idx_t    last,
   output rq_idx_t    gnt_idx,
   output logic       gnt_any
);

   always_comb begin
      gnt_any = |req;
      gnt_idx = 1'b0;
      case (req)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         // Contention: the requester that was not served last goes next.
         2'b11:   gnt_idx = ~last;
         default: gnt_idx = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                     |
// | Purpose  : Round-robin arbiter placing two cache controllers (typically    |
// |            I-side and D-side) in front of one physical memory port. One    |
// |            transaction is outstanding at a time and is held until Pmem     |
// |            reports completion.                                             |
// | Ports    : clk, rst (async, active low)                                    |
// |            rq_rd_en/rq_wd_en/rq_addr/rq_wd_data - per-requester request |
// |            rq_data, rq_data_valid, rq_wd_valid   - completion to req.   |
// |            mem_rd_en/mem_wd_en/mem_addr/mem_wd_data - to Pmem           |
// |            mem_data/mem_data_valid/mem_wd_valid  - from Pmem            |
// |            owner, busy                           - status               |
// |            timeout_err (only with ARB_TIMEOUT_EN)                       |
// | Options  : `define ARB_TIMEOUT_EN aborts a transaction after TIMEOUT busy  |
// |            cycles and pulses timeout_err.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = c_addr_w_def,
   parameter int DATA_W  = c_data_w_def,
   parameter int TIMEOUT = c_timeout_def
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            rq_rd_en,
   input  logic [1:0]            rq_wd_en,
   input  logic [1:0][ADDR_W-1:0] rq_addr,
   input  logic [1:0][DATA_W-1:0] rq_wd_data,
   output logic [DATA_W-1:0]     rq_data,
   output logic [1:0]            rq_data_valid,
   output logic [1:0]            rq_wd_valid,
   output logic                  mem_rd_en,
   output logic                  mem_wd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wd_data,
   input  logic [DATA_W-1:0]     mem_data,
   input  logic                  mem_data_valid,
   input  logic                  mem_wd_valid,
   output logic                  owner,
   output logic                  busy
`ifdef ARB_TIMEOUT_EN
   ,
   output logic                  timeout_err
`endif
);

   arb_state_t          r_state;
   logic                r_mem_rd_en;
   logic                r_mem_wd_en;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wd_data;
   rq_idx_t             r_owner;
   rq_idx_t             r_last;
   logic                r_busy;

   logic [1:0]          w_req;
   rq_idx_t             w_gnt_idx;
   logic                w_gnt_any;
   logic                w_rd_done;
   logic                w_wr_done;
   logic                w_done;

`ifdef ARB_TIMEOUT_EN
   localparam int c_tmo_w = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [c_tmo_w-1:0]  r_tmo_cnt;
   logic                r_timeout_err;
   logic                w_tmo_hit;
`endif

   // A requester is asking for the port if either enable is high.
   assign w_req = rq_rd_en | rq_wd_en;

   rr_pick u_rr_pick (
      .req     (w_req),
      .last    (r_last),
      .gnt_idx (w_gnt_idx),
      .gnt_any (w_gnt_any)
   );

   // Only the completion type matching the current transaction counts;
   // anything else (idle strays, wrong type) is dropped here.
   assign w_rd_done = (r_state == RD_BUSY) && mem_data_valid;
   assign w_wr_done = (r_state == WR_BUSY) && mem_wd_valid;
   assign w_done    = w_rd_done || w_wr_done;

`ifdef ARB_TIMEOUT_EN
   // Counter holds the number of busy cycles already completed, so the
   // abort fires at the edge ending busy cycle TIMEOUT.
   assign w_tmo_hit = (r_state != IDLE) && !w_done &&
                      (r_tmo_cnt == c_tmo_w'(TIMEOUT - 1));
   assign timeout_err = r_timeout_err;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_mem_rd_en   <= 1'b0;
         r_mem_wd_en   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wd_data <= '0;
         r_owner       <= 1'b0;
         r_last        <= 1'b1;   // requester 0 wins the first tie
         r_busy        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_tmo_cnt     <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         r_timeout_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
               r_tmo_cnt <= '0;
`endif
               if (w_gnt_any) begin
                  r_owner       <= w_gnt_idx;
                  r_busy        <= 1'b1;
                  r_mem_addr    <= rq_addr[w_gnt_idx];
                  r_mem_wd_data <= rq_wd_data[w_gnt_idx];
                  // Write-back goes before refill when both are raised.
                  if (rq_wd_en[w_gnt_idx]) begin
                     r_mem_wd_en <= 1'b1;
                     r_state     <= WR_BUSY;
                  end else begin
                     r_mem_rd_en <= 1'b1;
                     r_state     <= RD_BUSY;
                  end
               end
            end

            RD_BUSY, WR_BUSY: begin
               if (w_done) begin
                  r_mem_rd_en <= 1'b0;
                  r_mem_wd_en <= 1'b0;
                  r_busy      <= 1'b0;
                  r_last      <= r_owner;
                  r_state     <= IDLE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (w_tmo_hit) begin
                  r_mem_rd_en   <= 1'b0;
                  r_mem_wd_en   <= 1'b0;
                  r_busy        <= 1'b0;
                  r_last        <= r_owner;
                  r_state       <= IDLE;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end

            default: begin
               r_mem_rd_en <= 1'b0;
               r_mem_wd_en <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign mem_rd_en   = r_mem_rd_en;
   assign mem_wd_en   = r_mem_wd_en;
   assign mem_addr    = r_mem_addr;
   assign mem_wd_data = r_mem_wd_data;
   assign owner       = r_owner;
   assign busy        = r_busy;

   // Read data is broadcast; only the completion pulses are steered.
   assign rq_data       = mem_data;
   assign rq_data_valid = w_rd_done ? idx_onehot(r_owner) : 2'b00;
   assign rq_wd_valid   = w_wr_done ? idx_onehot(r_owner) : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                  |
// | Purpose  : Self-checking bench for mem_arbiter. A transaction-level model  |
// |            predicts every output each cycle; directed sequences add        |
// |            hand-computed literal expectations. Timeout scenario is built   |
// |            when ARB_TIMEOUT_EN is defined.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int TMO = 10;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [1:0]           rq_rd_en = '0;
   logic [1:0]           rq_wd_en = '0;
   logic [1:0][AW-1:0]   rq_addr = '0;
   logic [1:0][DW-1:0]   rq_wd_data = '0;
   logic [DW-1:0]        rq_data;
   logic [1:0]           rq_data_valid;
   logic [1:0]           rq_wd_valid;
   logic                 mem_rd_en;
   logic                 mem_wd_en;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_wd_data;
   logic [DW-1:0]        mem_data = '0;
   logic                 mem_data_valid = 1'b0;
   logic                 mem_wd_valid = 1'b0;
   logic                 owner;
   logic                 busy;
`ifdef ARB_TIMEOUT_EN
   logic                 timeout_err;
`endif

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk            (clk),
      .rst            (rst),
      .rq_rd_en       (rq_rd_en),
      .rq_wd_en       (rq_wd_en),
      .rq_addr        (rq_addr),
      .rq_wd_data     (rq_wd_data),
      .rq_data        (rq_data),
      .rq_data_valid  (rq_data_valid),
      .rq_wd_valid    (rq_wd_valid),
      .mem_rd_en      (mem_rd_en),
      .mem_wd_en      (mem_wd_en),
      .mem_addr       (mem_addr),
      .mem_wd_data    (mem_wd_data),
      .mem_data       (mem_data),
      .mem_data_valid (mem_data_valid),
      .mem_wd_valid   (mem_wd_valid),
      .owner          (owner),
      .busy           (busy)
`ifdef ARB_TIMEOUT_EN
      ,
      .timeout_err    (timeout_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // One outstanding transaction; who gets it next is "the requester other
   // than the last one served, if it is asking; otherwise whoever asks".
   bit          m_active = 0;
   bit          m_write  = 0;
   logic        m_owner  = 0;
   logic        m_last   = 1;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   int          m_cycles = 0;
   bit          m_tmo    = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 0; m_write = 0; m_owner = 0; m_last = 1;
         m_addr = '0; m_data = '0; m_cycles = 0; m_tmo = 0;
      end else begin
         m_tmo = 0;
         if (m_active) begin
            if (m_write ? mem_wd_valid : mem_data_valid) begin
               m_active = 0;
               m_last   = m_owner;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
               m_cycles++;
               if (m_cycles == TMO) begin
                  m_active = 0;
                  m_last   = m_owner;
                  m_tmo    = 1;
               end
            end
`endif
         end else if ((rq_rd_en | rq_wd_en) != 2'b00) begin
            logic [1:0] req;
            logic       other;
            logic       win;
            req      = rq_rd_en | rq_wd_en;
            other    = ~m_last;
            win      = req[other] ? other : m_last;
            m_active = 1;
            m_owner  = win;
            m_write  = rq_wd_en[win];
            m_addr   = rq_addr[win];
            m_data   = rq_wd_data[win];
            m_cycles = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [1:0] e_rdv;
      logic [1:0] e_wdv;
      e_rdv = 2'b00;
      e_wdv = 2'b00;
      if (m_active && !m_write && mem_data_valid) e_rdv = m_owner ? 2'b10 : 2'b01;
      if (m_active &&  m_write && mem_wd_valid)   e_wdv = m_owner ? 2'b10 : 2'b01;
      check("cmp_busy",      busy,          m_active);
      check("cmp_owner",     owner,         m_owner);
      check("cmp_rd_en",     mem_rd_en,     m_active && !m_write);
      check("cmp_wd_en",     mem_wd_en,     m_active && m_write);
      check("cmp_addr",      mem_addr,      m_addr);
      check("cmp_wd_data",   mem_wd_data,   m_data);
      check("cmp_rq_data",   rq_data,       mem_data);
      check("cmp_data_vld",  rq_data_valid, e_rdv);
      check("cmp_wd_vld",    rq_wd_valid,   e_wdv);
`ifdef ARB_TIMEOUT_EN
      check("cmp_tmo_err",   timeout_err,   m_tmo);
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_rd_en();
      int n = 0;
      while (mem_rd_en !== 1'b1 && n < 20) begin
         cyc(1);
         n++;
      end
      check("rd_grant_seen", mem_rd_en, 1'b1);
   endtask

   // Serve one read: check the issued address/owner, return data, then let
   // the requester drop its enable (and optionally re-raise it later).
   task automatic complete_read(input int idx, input logic [AW-1:0] exp_addr,
                                input logic [DW-1:0] data, input bit reraise);
      wait_rd_en();
      check("rd_addr",  mem_addr, exp_addr);
      check("rd_owner", owner,    idx[0]);
      cyc(1);
      mem_data       = data;
      mem_data_valid = 1'b1;
      @(negedge clk);
      check("rd_valid_pulse", rq_data_valid, (idx == 1) ? 2'b10 : 2'b01);
      check("rd_data",        rq_data,       data);
      cyc(1);
      mem_data_valid = 1'b0;
      rq_rd_en[idx]  = 1'b0;
      if (reraise) begin
         cyc(1);
         rq_rd_en[idx] = 1'b1;
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      check("reset_busy",  busy,      1'b0);
      check("reset_owner", owner,     1'b0);
      check("reset_addr",  mem_addr,  32'h0);
      check("reset_rd_en", mem_rd_en, 1'b0);

      // Single read, Pmem answers 3 cycles after the enable.
      rq_addr[0] = 32'h100;
      rq_rd_en   = 2'b01;
      cyc(1);
      check("t1_rd_en_latency", mem_rd_en, 1'b1);
      check("t1_addr",          mem_addr,  32'h100);
      check("t1_busy",          busy,      1'b1);
      cyc(2);
      mem_data       = 64'hDEADBEEF_00000001;
      mem_data_valid = 1'b1;
      @(negedge clk);
      check("t1_valid", rq_data_valid, 2'b01);
      check("t1_data",  rq_data,       64'hDEADBEEF_00000001);
      cyc(1);
      mem_data_valid = 1'b0;
      rq_rd_en       = 2'b00;
      check("t1_busy_fall", busy, 1'b0);

      // Tie fairness from reset: r0, r1, r0, r1.
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      rq_addr[0] = 32'h10;
      rq_addr[1] = 32'h20;
      rq_rd_en   = 2'b11;
      complete_read(0, 32'h10, 64'h1111, 1'b1);
      complete_read(1, 32'h20, 64'h2222, 1'b1);
      complete_read(0, 32'h10, 64'h3333, 1'b0);
      complete_read(1, 32'h20, 64'h4444, 1'b0);
      cyc(2);
      check("t2_idle", busy, 1'b0);

      // Write priority within one requester, then read after a bubble.
      rq_addr[1]    = 32'h40;
      rq_wd_data[1] = 64'h55;
      rq_rd_en      = 2'b10;
      rq_wd_en      = 2'b10;
      cyc(1);
      check("t3_wd_en",   mem_wd_en,   1'b1);
      check("t3_rd_en",   mem_rd_en,   1'b0);
      check("t3_wd_data", mem_wd_data, 64'h55);
      check("t3_owner",   owner,       1'b1);
      cyc(1);
      mem_wd_valid = 1'b1;
      @(negedge clk);
      check("t3_wd_valid", rq_wd_valid,   2'b10);
      check("t3_no_rdv",   rq_data_valid, 2'b00);
      cyc(1);
      mem_wd_valid = 1'b0;
      rq_wd_en     = 2'b00;
      check("t3_bubble", mem_rd_en, 1'b0);
      cyc(1);
      check("t3_read_after", mem_rd_en, 1'b1);
      complete_read(1, 32'h40, 64'h4040, 1'b0);

      // Stray completions are never forwarded.
      mem_data_valid = 1'b1;
      @(negedge clk);
      check("t4_idle_stray", rq_data_valid, 2'b00);
      cyc(1);
      mem_data_valid = 1'b0;
      rq_addr[0]     = 32'h80;
      rq_rd_en       = 2'b01;
      cyc(1);
      mem_wd_valid = 1'b1;
      @(negedge clk);
      check("t4_wrong_type", rq_wd_valid, 2'b00);
      cyc(1);
      mem_wd_valid = 1'b0;
      check("t4_still_busy", busy,      1'b1);
      check("t4_still_rd",   mem_rd_en, 1'b1);
      complete_read(0, 32'h80, 64'h8080, 1'b0);

      // Asynchronous reset two cycles into a read.
      rq_addr[1] = 32'h20;
      rq_rd_en   = 2'b10;
      cyc(1);
      check("t5_started", mem_rd_en, 1'b1);
      cyc(2);
      #2 rst = 1'b0;
      #1;
      check("t5_rd_en_drop", mem_rd_en, 1'b0);
      check("t5_busy_drop",  busy,      1'b0);
      rq_rd_en       = 2'b00;
      mem_data_valid = 1'b1;
      @(negedge clk);
      check("t5_no_valid", rq_data_valid, 2'b00);
      cyc(2);
      mem_data_valid = 1'b0;
      rst            = 1'b1;
      rq_addr[0]     = 32'h10;
      rq_rd_en       = 2'b11;
      complete_read(0, 32'h10, 64'hA0, 1'b0);
      complete_read(1, 32'h20, 64'hA1, 1'b0);

`ifdef ARB_TIMEOUT_EN
      // No Pmem response: abort after TMO busy cycles, then serve the other.
      begin
         int bc = 0;
         cyc(1);
         rq_rd_en = 2'b11;
         wait_rd_en();
         check("t6_owner", owner, 1'b0);
         while (timeout_err !== 1'b1 && bc < 40) begin
            if (busy) bc++;
            cyc(1);
         end
         check("t6_tmo_seen",   timeout_err, 1'b1);
         check("t6_busy_count", bc,          TMO);
         check("t6_enables",    mem_rd_en,   1'b0);
         check("t6_culprit",    owner,       1'b0);
         rq_rd_en[0] = 1'b0;
         complete_read(1, 32'h20, 64'hB1, 1'b0);
      end
`endif

      cyc(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
